uart_tx_sequencer: RTL and testbench

// Bus master that sequences the memory-mapped UART_Component on behalf of two byte producers.

---
 rtl/uart_tx_sequencer.sv | 152 +++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// Round-robin bus master that polls a memory-mapped UART status register and writes
// one byte per granted request. All outputs are registered and decoded from the next state.
module uart_tx_sequencer #(
    parameter logic [3:0]  ADDR_STATUS = 4'h0,
    parameter logic [3:0]  ADDR_TX     = 4'h1,
    parameter int unsigned TX_BUSY_BIT = 0,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [3:0] addr,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       grant,
    output logic       timeout_err,
    output logic [2:0] state_dbg
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] POLL_RD   = 3'd1;
    localparam logic [2:0] POLL_WAIT = 3'd2;
    localparam logic [2:0] CHECK     = 3'd3;
    localparam logic [2:0] WRITE     = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    localparam int unsigned PW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW:0] TO_L = TIMEOUT[PW:0];

    logic [2:0]    state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          grant_q, grant_d;
    logic          rr_q, rr_d;
    logic          err_q, err_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW:0]   cnt_inc;
    logic          cs_q, rd_q, wr_q, ready0_q, ready1_q, busy_q, terr_q;
    logic [3:0]    addr_q, addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          unused_rd;

    assign unused_rd = ^rd_data;
    assign cnt_inc   = {1'b0, cnt_q} + {{PW{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = (req0_valid && req1_valid) ? rr_q : req1_valid;
                    data_d  = grant_d ? req1_data : req0_data;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = POLL_RD;
                end
            end
            POLL_RD:   state_d = POLL_WAIT;
            POLL_WAIT: state_d = CHECK;
            CHECK: begin
                if (!rd_data[TX_BUSY_BIT]) begin
                    state_d = WRITE;
                end else begin
                    // Saturate rather than wrap so "poll forever" never aliases to zero.
                    cnt_d = cnt_inc[PW] ? cnt_q : cnt_inc[PW-1:0];
                    if (TIMEOUT != 0 && cnt_inc == TO_L) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = POLL_RD;
                    end
                end
            end
            WRITE: state_d = DONE;
            DONE: begin
                rr_d    = ~grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        if (state_d == POLL_RD) addr_d = ADDR_STATUS;
        if (state_d == WRITE) begin
            addr_d    = ADDR_TX;
            wr_data_d = data_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            data_q    <= 8'h00;
            grant_q   <= 1'b0;
            rr_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            cs_q      <= 1'b1;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            addr_q    <= 4'h0;
            wr_data_q <= 8'h00;
            ready0_q  <= 1'b0;
            ready1_q  <= 1'b0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            cs_q      <= !(state_d == POLL_RD || state_d == WRITE);
            rd_q      <= !(state_d == POLL_RD);
            wr_q      <= !(state_d == WRITE);
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            ready0_q  <= (state_d == DONE) && !grant_q;
            ready1_q  <= (state_d == DONE) && grant_q;
            busy_q    <= (state_d != IDLE);
            terr_q    <= (state_d == DONE) && err_d;
        end
    end

    assign req0_ready  = ready0_q;
    assign req1_ready  = ready1_q;
    assign cs          = cs_q;
    assign rd          = rd_q;
    assign wr          = wr_q;
    assign addr        = addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign grant       = grant_q;
    assign timeout_err = terr_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: UART status/write model on the bus side,
// one task per scenario with inline checks against hand-computed values.
module tb_uart_tx_sequencer;
  logic clock = 1'b0;
  logic reset;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic cs, rd, wr, busy, grant, timeout_err;
  logic [3:0] addr;
  logic [7:0] wr_data, rd_data;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;
  int n_reads = 0, n_writes = 0, overlap = 0, bad_addr = 0, n_rdy0 = 0;
  int read_base = 0, busy_target = 0;
  logic always_busy = 1'b0;
  logic [7:0] wq[$];

  always #5 clock = ~clock;

  uart_tx_sequencer #(.ADDR_STATUS(4'h0), .ADDR_TX(4'h1), .TX_BUSY_BIT(0), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .cs(cs), .rd(rd), .wr(wr), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .busy(busy), .grant(grant), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // UART status model: the k-th read since read_base reports busy while k <= busy_target
  always @(posedge clock) begin
    if (!reset) rd_data <= 8'h00;
    else if (!cs && !rd) rd_data <= (always_busy || (n_reads - read_base) <= busy_target) ? 8'h01 : 8'h00;
  end

  always @(negedge clock) begin
    if (!cs && !rd) begin
      n_reads++;
      if (addr !== 4'h0) bad_addr++;
    end
    if (!cs && !wr) begin
      n_writes++;
      wq.push_back(wr_data);
      if (addr !== 4'h1) bad_addr++;
    end
    if (!rd && !wr) overlap++;
    if (req0_ready === 1'b1) n_rdy0++;
  end

  task automatic do_reset();
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic run_req(input int id, input logic [7:0] d, input int drop_after,
                         output int lat, output logic terr, output logic gnt, output logic other);
    lat = 0; terr = 1'b0; gnt = 1'b0; other = 1'b0;
    if (id == 0) begin req0_data = d; req0_valid = 1'b1; end
    else begin req1_data = d; req1_valid = 1'b1; end
    for (int k = 1; k <= 300; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (((id == 0) ? req0_ready : req1_ready) === 1'b1) begin
        lat = k; terr = timeout_err; gnt = grant;
        other = (id == 0) ? req1_ready : req0_ready;
        break;
      end
      if (k == drop_after) begin
        if (id == 0) begin req0_valid = 1'b0; req0_data = 8'hFF; end
        else begin req1_valid = 1'b0; req1_data = 8'hFF; end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (lat == 0) begin errors++; $display("FAIL ready_wait: no ready for requester %0d within 300 cycles", id); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({cs, rd, wr} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b want 111", {cs, rd, wr}); end
    checks++; if (addr !== 4'h0 || wr_data !== 8'h00) begin errors++; $display("FAIL reset_bus: addr=%h wr_data=%h want 0/00", addr, wr_data); end
    checks++; if ({req0_ready, req1_ready, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_acks: got %b want 000", {req0_ready, req1_ready, timeout_err}); end
    checks++; if ({busy, grant} !== 2'b00 || state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: busy=%b grant=%b state=%0d want 0 0 0", busy, grant, state_dbg); end
  endtask

  task automatic test_single();
    int lat, wbase; logic terr, gnt, other;
    busy_target = 0; always_busy = 1'b0; read_base = n_reads; wbase = n_writes;
    run_req(0, 8'hA5, 0, lat, terr, gnt, other);
    checks++; if (lat !== 5) begin errors++; $display("FAIL single_latency: got %0d want 5", lat); end
    checks++; if (n_reads - read_base !== 1) begin errors++; $display("FAIL single_reads: got %0d want 1", n_reads - read_base); end
    checks++; if (n_writes - wbase !== 1) begin errors++; $display("FAIL single_writes: got %0d want 1", n_writes - wbase); end
    checks++; if (wq.size() <= wbase || wq[wbase] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", (wq.size() > wbase) ? wq[wbase] : 8'hxx); end
    checks++; if ({terr, gnt, other} !== 3'b000) begin errors++; $display("FAIL single_flags: terr/grant/other=%b want 000", {terr, gnt, other}); end
    @(negedge clock);
    checks++; if ({busy, req0_ready} !== 2'b00) begin errors++; $display("FAIL single_after: busy/ready=%b want 00", {busy, req0_ready}); end
  endtask

  task automatic test_back_to_back();
    int wbase, nr, cyc, last;
    int ids[$]; int gaps[$]; logic gq[$];
    do_reset();
    wbase = n_writes; nr = 0; last = 0; read_base = n_reads;
    req0_data = 8'h11; req1_data = 8'h22; req0_valid = 1'b1; req1_valid = 1'b1;
    for (cyc = 1; cyc <= 200 && nr < 4; cyc++) begin
      @(posedge clock);
      @(negedge clock);
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        ids.push_back(req1_ready ? 1 : 0);
        gq.push_back(grant);
        if (nr > 0) gaps.push_back(cyc - last);
        last = cyc; nr++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (nr !== 4) begin errors++; $display("FAIL b2b_count: got %0d acks want 4", nr); end
    for (int i = 0; i < nr; i++) begin
      checks++;
      if (ids[i] !== i % 2 || gq[i] !== 1'(i % 2) || wq.size() <= wbase + i || wq[wbase + i] !== ((i % 2) ? 8'h22 : 8'h11)) begin
        errors++; $display("FAIL b2b_order[%0d]: id=%0d grant=%b data=%h want id=%0d data=%h", i, ids[i], gq[i], (wq.size() > wbase + i) ? wq[wbase + i] : 8'hxx, i % 2, (i % 2) ? 8'h22 : 8'h11);
      end
    end
    for (int i = 0; i < gaps.size(); i++) begin
      checks++; if (gaps[i] !== 6) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d cycles want 6", i, gaps[i]); end
    end
    @(negedge clock);
  endtask

  task automatic test_busy_polls();
    int lat, wbase; logic terr, gnt, other;
    busy_target = 3; always_busy = 1'b0; read_base = n_reads; wbase = n_writes;
    run_req(0, 8'h5A, 0, lat, terr, gnt, other);
    checks++; if (lat !== 14) begin errors++; $display("FAIL busy_latency: got %0d want 14", lat); end
    checks++; if (n_reads - read_base !== 4) begin errors++; $display("FAIL busy_reads: got %0d want 4", n_reads - read_base); end
    checks++; if (n_writes - wbase !== 1 || wq.size() <= wbase || wq[wbase] !== 8'h5A) begin errors++; $display("FAIL busy_write: writes=%0d want 1 of 5a", n_writes - wbase); end
    checks++; if (terr !== 1'b0) begin errors++; $display("FAIL busy_terr: got %b want 0", terr); end
    busy_target = 0;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int lat, wbase; logic terr, gnt, other;
    always_busy = 1'b1; read_base = n_reads; wbase = n_writes;
    run_req(1, 8'h77, 0, lat, terr, gnt, other);
    checks++; if (lat !== 25) begin errors++; $display("FAIL timeout_latency: got %0d want 25", lat); end
    checks++; if (n_reads - read_base !== 8) begin errors++; $display("FAIL timeout_reads: got %0d want 8", n_reads - read_base); end
    checks++; if (n_writes - wbase !== 0) begin errors++; $display("FAIL timeout_writes: got %0d want 0", n_writes - wbase); end
    checks++; if ({terr, gnt} !== 2'b11) begin errors++; $display("FAIL timeout_flag: terr/grant=%b want 11", {terr, gnt}); end
    @(negedge clock);
    checks++; if ({timeout_err, req1_ready} !== 2'b00) begin errors++; $display("FAIL timeout_pulse: terr/ready=%b want 00", {timeout_err, req1_ready}); end
    always_busy = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int lat, wbase, rdy0_base; logic terr, gnt, other, found;
    always_busy = 1'b1; found = 1'b0;
    req0_data = 8'h99; req0_valid = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clock);
      if (state_dbg === 3'd2) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midflight_reach: POLL_WAIT not reached, state=%0d", state_dbg); end
    rdy0_base = n_rdy0;
    #2 reset = 1'b0;
    #1;
    checks++; if ({cs, rd, wr, busy} !== 4'b1110 || state_dbg !== 3'd0) begin errors++; $display("FAIL midflight_async: cs/rd/wr/busy=%b state=%0d want 1110 0", {cs, rd, wr, busy}, state_dbg); end
    req0_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1; always_busy = 1'b0;
    @(negedge clock);
    read_base = n_reads; wbase = n_writes;
    run_req(1, 8'hC3, 0, lat, terr, gnt, other);
    checks++; if (lat !== 5 || gnt !== 1'b1) begin errors++; $display("FAIL midflight_next: lat=%0d grant=%b want 5 1", lat, gnt); end
    checks++; if (n_writes - wbase !== 1 || wq.size() <= wbase || wq[wbase] !== 8'hC3) begin errors++; $display("FAIL midflight_write: writes=%0d want 1 of c3", n_writes - wbase); end
    checks++; if (n_rdy0 !== rdy0_base) begin errors++; $display("FAIL midflight_noack: got %0d req0 acks want 0", n_rdy0 - rdy0_base); end
    @(negedge clock);
  endtask

  task automatic test_drop_valid();
    int lat, wbase; logic terr, gnt, other;
    read_base = n_reads; wbase = n_writes;
    run_req(1, 8'h3C, 2, lat, terr, gnt, other);
    checks++; if (lat !== 5) begin errors++; $display("FAIL drop_latency: got %0d want 5", lat); end
    checks++; if (n_writes - wbase !== 1 || wq.size() <= wbase || wq[wbase] !== 8'h3C) begin errors++; $display("FAIL drop_data: writes=%0d got %h want 3c", n_writes - wbase, (wq.size() > wbase) ? wq[wbase] : 8'hxx); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_polls();
    test_timeout();
    test_reset_midflight();
    test_drop_valid();
    checks++; if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap: rd and wr low together %0d times", overlap); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL strobe_addr: %0d strobes at wrong address", bad_addr); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
